// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer, LSB first, one bit per clock
// Optional subtract mode: define SERIAL_ADDER_SUB_EN to add the sub port.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // One-hot so busy/done come straight off state flops.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    DONE = 3'b100
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             accept;
  logic             last_bit;
  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] b_load;
  logic             carry_init;

  assign accept   = start && (state == IDLE || state == DONE);
  assign last_bit = (state == RUN) && (cnt == LAST);
  assign bit_s    = a_sr[0] ^ b_sr[0] ^ carry;
  assign bit_c    = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

`ifdef SERIAL_ADDER_SUB_EN
  // Two's complement subtract: invert B and seed the carry with 1.
  assign b_load     = sub ? ~b : b;
  assign carry_init = sub;
`else
  assign b_load     = b;
  assign carry_init = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last_bit) state_nx = DONE;
      DONE:    state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = state[1];
    done = state[2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b_load;
      cnt   <= '0;
      carry <= carry_init;
    end else if (state == RUN) begin
      a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
      sum   <= {bit_s, sum[WIDTH-1:1]};
      carry <= bit_c;
      if (last_bit) cout <= bit_c;
      else          cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl (WIDTH=8)
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int n_assert = 0;
  int n_fail   = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the captured operands.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                       output logic [W-1:0] es, output logic ec);
    int unsigned r;
    if (sv) begin
      es = W'((av - bv) % (1 << W));
      ec = (av >= bv);
    end else begin
      r  = int'(av) + int'(bv);
      es = W'(r % (1 << W));
      ec = (r >= (1 << W));
    end
  endtask

  // One transaction; optionally scramble operands after the accepting edge.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                       input bit scramble, input string tag);
    logic [W-1:0] es;
    logic         ec;
    model(av, bv, sv, es, ec);
    @(negedge clk);
    a = av; b = bv; sub = sv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin a = '1; b = '1; sub = ~sv; end
    check({tag, "_busy_e0"}, busy, 1);
    check({tag, "_done_e0"}, done, 0);
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      check({tag, "_busy_run"}, busy, 1);
      check({tag, "_done_run"}, done, 0);
    end
    @(negedge clk);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_done"}, done, 1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    @(negedge clk);
    check({tag, "_done_drop"}, done, 0);
    check({tag, "_busy_idle"}, busy, 0);
    check({tag, "_sum_hold"}, sum, es);
    check({tag, "_cout_hold"}, cout, ec);
  endtask

  initial begin
    int pulses;
    int last_pulse;
    logic [W-1:0] ra, rb;
    logic rs;

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h0F, 8'h01, 1'b0, 0, "p0f_01");
    do_op(8'hFF, 8'h01, 1'b0, 0, "pff_01");
    do_op(8'hA5, 8'h5A, 1'b0, 0, "pa5_5a");
    do_op(8'h12, 8'h34, 1'b0, 1, "midrun");
    do_op(8'h00, 8'h00, 1'b0, 0, "zero");
    do_op(8'hFF, 8'hFF, 1'b0, 0, "max");

    // Start held high: back-to-back results every W+1 cycles.
    @(negedge clk);
    a = 8'h03; b = 8'h04; sub = 1'b0; start = 1'b1;
    pulses = 0; last_pulse = 0;
    for (int cyc = 1; cyc <= 4 * (W + 1); cyc++) begin
      @(negedge clk);
      check("b2b_exclusive", busy & done, 0);
      if (done) begin
        check("b2b_sum", sum, 8'h07);
        check("b2b_cout", cout, 0);
        check("b2b_spacing", cyc - last_pulse, (pulses == 0) ? W + 1 : W + 1);
        pulses++;
        last_pulse = cyc;
      end
    end
    check("b2b_pulses", pulses, 4);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b2b_idle", busy | done, 0);

    // Asynchronous reset in the 4th RUN cycle aborts without a done.
    @(negedge clk);
    a = 8'h80; b = 8'h80; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sum", sum, 0);
    check("arst_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check("arst_no_done", done | busy, 0);
    end
    do_op(8'h80, 8'h80, 1'b0, 0, "post_rst");

`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h05, 8'h07, 1'b1, 0, "sub_05_07");
    do_op(8'h07, 8'h05, 1'b1, 0, "sub_07_05");
    do_op(8'h33, 8'h33, 1'b1, 0, "sub_eq");
`endif

    for (int k = 0; k < 20; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      do_op(ra, rb, rs, ($urandom_range(0, 1) == 1), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
